// File: rtl/uart_msg_pkg.sv
// Shared encodings for the UART frame receiver: FSM states, error codes, header byte offsets.
// Frame layout is [len, 0x00, 0x00, type, payload...]; optional trailing checksum under UART_MSG_CHECKSUM_EN.
package uart_msg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DONE    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_RSVD    = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_OVERRUN = 3'd4;
    localparam logic [2:0] ERR_CSUM    = 3'd5;
    localparam logic [2:0] ERR_FRAMING = 3'd6;

    localparam logic [7:0] OFF_LEN     = 8'd0;
    localparam logic [7:0] OFF_RSVD_LO = 8'd1;
    localparam logic [7:0] OFF_RSVD_HI = 8'd2;
    localparam logic [7:0] OFF_TYPE    = 8'd3;
    localparam logic [7:0] OFF_PAYLOAD = 8'd4;

endpackage

// File: rtl/uart_msg_rx_timer.sv
// Idle timer: counts enabled cycles since the last clear, flags expiry at TIMEOUT_CYCLES-1.
// Expired is combinational from the count; the count holds at the limit until cleared.
module uart_idle_timer #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_msg_rx.sv
// Assembles length-prefixed UART frames into one message on valid/ready; msg_valid and err_pulse follow the cause by 1 cycle.
// While a message waits for msg_ready, further bytes are dropped with OVERRUN. UART_MSG_CHECKSUM_EN adds a zero-sum trailer byte.
module uart_msg_rx
    import uart_msg_pkg::*;
#(
    parameter int MSG_BUF_LEN    = 60,
    parameter int MIN_LEN        = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_error,
    output logic                     msg_valid,
    input  logic                     msg_ready,
    output logic [7:0]               msg_len,
    output logic [7:0]               msg_type,
    output logic [MSG_BUF_LEN*8-1:0] msg_payload,
    output logic                     err_pulse,
    output logic [2:0]               err_code,
    output logic                     busy
);

    localparam logic [7:0] MIN_LEN_B = 8'(MIN_LEN);
    localparam logic [7:0] MAX_LEN_B = 8'(MSG_BUF_LEN);

    state_t                   state_q, state_d;
    logic [7:0]               idx_q, idx_d;
    logic [7:0]               len_q, len_d;
    logic [7:0]               type_q, type_d;
    logic [MSG_BUF_LEN*8-1:0] payload_q, payload_d;
    logic                     msg_valid_q, msg_valid_d;
    logic                     err_pulse_q, err_pulse_d;
    logic [2:0]               err_code_q, err_code_d;
`ifdef UART_MSG_CHECKSUM_EN
    logic [7:0]               sum_q, sum_d;
`endif

    logic take_len, last_byte, timer_en, expired;

    assign timer_en = (state_q == ST_HDR) || (state_q == ST_PAYLOAD) || (state_q == ST_DRAIN);

    uart_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clear   (rx_valid || !timer_en),
        .enable  (timer_en),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        type_d      = type_q;
        payload_d   = payload_q;
        msg_valid_d = msg_valid_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        take_len    = 1'b0;
        last_byte   = (idx_q == len_q - 8'd1);
`ifdef UART_MSG_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_error) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_FRAMING;
                end else begin
                    take_len = rx_valid;
                end
            end
            ST_HDR: begin
                if (rx_error) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_FRAMING;
                    state_d     = ST_DRAIN;
                end else if (rx_valid) begin
                    idx_d = idx_q + 8'd1;
`ifdef UART_MSG_CHECKSUM_EN
                    sum_d = sum_q + rx_byte;
`endif
                    if (idx_q == OFF_TYPE) begin
                        type_d  = rx_byte;
                        state_d = ST_PAYLOAD;
                    end else if (idx_q <= OFF_RSVD_HI && rx_byte != 8'h00) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_RSVD;
                        state_d     = ST_DRAIN;
                    end
                end else if (expired) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (rx_error) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_FRAMING;
                    state_d     = ST_DRAIN;
                end else if (rx_valid) begin
                    idx_d = idx_q + 8'd1;
`ifdef UART_MSG_CHECKSUM_EN
                    // The trailer byte only closes the running sum; it never lands in the payload.
                    sum_d = sum_q + rx_byte;
                    if (!last_byte) begin
                        payload_d[8*int'(idx_q - OFF_PAYLOAD) +: 8] = rx_byte;
                    end else if (sum_d == 8'h00) begin
                        msg_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                        payload_d   = '0;
                        state_d     = ST_IDLE;
                    end
`else
                    payload_d[8*int'(idx_q - OFF_PAYLOAD) +: 8] = rx_byte;
                    if (last_byte) begin
                        msg_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
`endif
                end else if (expired) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    payload_d   = '0;
                    state_d     = ST_IDLE;
                end
            end
            ST_DONE: begin
                // A byte in the handshake cycle already belongs to the next frame.
                if (msg_ready) begin
                    msg_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    take_len    = rx_valid;
                end else if (rx_valid) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
            end
            ST_DRAIN: begin
                if (expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take_len && rx_byte != 8'h00) begin
            if (rx_byte < MIN_LEN_B || rx_byte > MAX_LEN_B) begin
                err_pulse_d = 1'b1;
                err_code_d  = ERR_LEN;
                state_d     = ST_DRAIN;
            end else begin
                len_d     = rx_byte;
                payload_d = '0;
                idx_d     = OFF_RSVD_LO;
                state_d   = ST_HDR;
`ifdef UART_MSG_CHECKSUM_EN
                sum_d     = rx_byte;
`endif
            end
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= OFF_LEN;
            len_q       <= '0;
            type_q      <= '0;
            payload_q   <= '0;
            msg_valid_q <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= '0;
`ifdef UART_MSG_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            type_q      <= type_d;
            payload_q   <= payload_d;
            msg_valid_q <= msg_valid_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
`ifdef UART_MSG_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign msg_valid   = msg_valid_q;
    assign msg_len     = len_q;
    assign msg_type    = type_q;
    assign msg_payload = payload_q;
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_msg_rx.sv
// Directed bench for uart_msg_rx: expected messages/errors are queued when frames are driven and popped by a monitor.
module tb_uart_msg_rx;
    import uart_msg_pkg::*;

    localparam int BUF  = 60;
    localparam int MINL = 8;
    localparam int TO   = 64;

    logic             sys_clk = 1'b0;
    logic             reset, rx_valid, rx_error, msg_ready;
    logic [7:0]       rx_byte;
    logic             msg_valid, err_pulse, busy;
    logic [7:0]       msg_len, msg_type;
    logic [BUF*8-1:0] msg_payload;
    logic [2:0]       err_code;

    uart_msg_rx #(.MSG_BUF_LEN(BUF), .MIN_LEN(MINL), .TIMEOUT_CYCLES(TO)) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .rx_error    (rx_error),
        .msg_valid   (msg_valid),
        .msg_ready   (msg_ready),
        .msg_len     (msg_len),
        .msg_type    (msg_type),
        .msg_payload (msg_payload),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [7:0]       len;
        logic [7:0]       typ;
        logic [BUF*8-1:0] pay;
    } msg_t;

    msg_t       msg_q [$];
    logic [2:0] err_q [$];
    msg_t       mon_m, m4;
    bq_t        fr;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string tag, input logic [BUF*8-1:0] obs, input logic [BUF*8-1:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic bq_t make_frame(input int len, input logic [7:0] typ, input int seed);
        bq_t        f;
        logic [7:0] s;
        f = {8'(len), 8'h00, 8'h00, typ};
        for (int i = 4; i < len; i++) f.push_back(8'((seed + i * 37) & 255));
`ifdef UART_MSG_CHECKSUM_EN
        s = 8'h00;
        for (int i = 0; i < len - 1; i++) s = s + f[i];
        f[len-1] = 8'h00 - s;
`else
        s = 8'h00;
`endif
        return f;
    endfunction

    // Reference model of a complete frame: queues the message it must produce, or the checksum error.
    function automatic msg_t exp_frame(input bq_t f);
        msg_t       m;
        int         plen;
        logic [7:0] s;
        m.len = f[0];
        m.typ = f[3];
        m.pay = '0;
        plen  = int'(f[0]) - 4;
        s     = 8'h00;
`ifdef UART_MSG_CHECKSUM_EN
        plen = plen - 1;
        foreach (f[i]) s = s + f[i];
        if (s != 8'h00) begin
            err_q.push_back(ERR_CSUM);
            return m;
        end
`endif
        for (int k = 0; k < plen; k++) m.pay[8*k +: 8] = f[4+k];
        msg_q.push_back(m);
        return m;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk);
        #1;
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge sys_clk);
        #1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic send_frame(input bq_t f);
        foreach (f[i]) send_byte(f[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    always @(negedge sys_clk) begin
        if (!reset) begin
            if (msg_valid && msg_ready) begin
                chk("msg_expected", msg_q.size() != 0, 1'b1);
                if (msg_q.size() != 0) begin
                    mon_m = msg_q.pop_front();
                    chk("msg_len", msg_len, mon_m.len);
                    chk("msg_type", msg_type, mon_m.typ);
                    chk("msg_payload", msg_payload, mon_m.pay);
                end
            end
            if (err_pulse) begin
                chk("err_expected", err_q.size() != 0, 1'b1);
                if (err_q.size() != 0) chk("err_code", err_code, err_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; rx_error = 1'b0; msg_ready = 1'b0;
        idle(3);
        chk("rst_msg_valid", msg_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err_pulse", err_pulse, 1'b0);
        chk("rst_err_code", err_code, 3'd0);
        chk("rst_len_type", {msg_len, msg_type}, 16'h0);
        chk("rst_payload", msg_payload, '0);
        reset = 1'b0;
        idle(2);

        // 1: basic frame, consumer always ready
        msg_ready = 1'b1;
`ifdef UART_MSG_CHECKSUM_EN
        fr = {8'h08, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'hF2};
`else
        fr = {8'h08, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`endif
        void'(exp_frame(fr));
        send_frame(fr);
        chk("t1_valid", msg_valid, 1'b1);
`ifndef UART_MSG_CHECKSUM_EN
        chk("t1_payload_word", msg_payload[31:0], 32'hEFBEADDE);
`endif
        idle(1);
        chk("t1_valid_one_cycle", msg_valid, 1'b0);
        chk("t1_busy", busy, 1'b0);

        // keepalive zero byte in IDLE is ignored
        send_byte(8'h00);
        chk("keepalive_busy", busy, 1'b0);

        // 2: short length, drain, then a good frame
        err_q.push_back(ERR_LEN);
        send_byte(8'h05);
        chk("t2_drain_busy", busy, 1'b1);
        idle(TO + 5);
        chk("t2_drain_exit", busy, 1'b0);
        fr = make_frame(8, 8'h11, 3);
        void'(exp_frame(fr));
        send_frame(fr);
        idle(3);

        // 3: truncated frame times out
        err_q.push_back(ERR_TIMEOUT);
        send_frame({8'h10, 8'h00, 8'h00, 8'h01, 8'hA1, 8'hA2, 8'hA3});
        chk("t3_busy_open", busy, 1'b1);
        for (int i = 0; i < TO + 10 && !err_pulse; i++) idle(1);
        chk("t3_timeout_seen", err_pulse, 1'b1);
        chk("t3_busy_after", busy, 1'b0);
        chk("t3_no_valid", msg_valid, 1'b0);
        idle(2);

        // 4: message held while not ready; extra byte is an overrun
        msg_ready = 1'b0;
        fr = make_frame(12, 8'h22, 5);
        m4 = exp_frame(fr);
        send_frame(fr);
        chk("t4_valid", msg_valid, 1'b1);
        err_q.push_back(ERR_OVERRUN);
        send_byte(8'h55);
        idle(2);
        chk("t4_hold_valid", msg_valid, 1'b1);
        chk("t4_hold_len", msg_len, m4.len);
        chk("t4_hold_type", msg_type, m4.typ);
        chk("t4_hold_payload", msg_payload, m4.pay);
        msg_ready = 1'b1;
        idle(1);
        chk("t4_released", msg_valid, 1'b0);

        // 5: bad reserved byte, later bytes silently drained
        err_q.push_back(ERR_RSVD);
        send_frame({8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE});
        chk("t5_drain_busy", busy, 1'b1);
        idle(TO + 5);
        chk("t5_drain_exit", busy, 1'b0);

        // 6: last byte F3 (bad checksum when enabled, plain payload otherwise)
        fr = {8'h08, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'hF3};
        void'(exp_frame(fr));
        send_frame(fr);
        idle(3);

        // boundaries: maximum length accepted, one above rejected
        fr = make_frame(BUF, 8'h3C, 9);
        void'(exp_frame(fr));
        send_frame(fr);
        idle(3);
        err_q.push_back(ERR_LEN);
        send_byte(8'(BUF + 1));
        idle(TO + 5);
        chk("over_max_drained", busy, 1'b0);

        // framing error while idle
        err_q.push_back(ERR_FRAMING);
        @(posedge sys_clk); #1; rx_error = 1'b1;
        @(posedge sys_clk); #1; rx_error = 1'b0;
        chk("framing_idle_busy", busy, 1'b0);
        idle(2);

        // reset mid-frame, then recovery
        send_frame({8'h08, 8'h00});
        reset = 1'b1;
        idle(1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_len", msg_len, 8'h00);
        reset = 1'b0;
        idle(1);
        chk("midrst_no_err", err_pulse, 1'b0);
        fr = make_frame(9, 8'h44, 17);
        void'(exp_frame(fr));
        send_frame(fr);
        idle(5);

        chk("msgs_all_seen", msg_q.size(), 0);
        chk("errs_all_seen", err_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
